// File: rtl/ascon_permutation_sequencer.sv
// ascon_permutation_sequencer
// Round-iterative controller for the Ascon-p permutation. A 320-bit state
// and a round count are accepted over a valid/ready handshake, the state is
// iterated one round per cycle (constant addition, S-box layer, linear
// diffusion), and the permuted state is returned over a second handshake.
//
// State layout: a packed 5x64 array matching ascon_state_t, [0] = S0 ... [4] = S4.
//
// Optional feature: define ASCON_PERM_UNROLL2_EN to chain two round
// datapaths so that each RUN cycle applies rounds k and k+1. When the
// macro is undefined, one round is applied per cycle.

module ascon_permutation_sequencer #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0][63:0] state_i,
    input  logic [4:0]       nr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0][63:0] state_o,
    output logic             busy_o
);

    localparam logic [4:0] MAX_NR = 5'(MAX_ROUNDS);

    // Elaboration-time guard on the legal round bound.
    if (MAX_ROUNDS < 1 || MAX_ROUNDS > 16) begin : g_bad_max_rounds
        $error("ascon_permutation_sequencer: MAX_ROUNDS must lie in 1..16");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t             fsm_q;
    fsm_t             fsm_d;
    logic [4:0][63:0] perm_q;
    logic [4:0][63:0] round_next;
    logic [4:0]       round_q;
    logic [4:0]       nr_eff;
    logic [4:0]       round_start;
    logic [4:0]       round_step;
    logic             accept;
    logic             last_cycle;

    // Ascon 5-bit S-box; the column index has S0 as its most significant bit.
    function automatic logic [4:0] sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04;
            5'h01: y = 5'h0b;
            5'h02: y = 5'h1f;
            5'h03: y = 5'h14;
            5'h04: y = 5'h1a;
            5'h05: y = 5'h15;
            5'h06: y = 5'h09;
            5'h07: y = 5'h02;
            5'h08: y = 5'h1b;
            5'h09: y = 5'h05;
            5'h0a: y = 5'h08;
            5'h0b: y = 5'h12;
            5'h0c: y = 5'h1d;
            5'h0d: y = 5'h03;
            5'h0e: y = 5'h06;
            5'h0f: y = 5'h1c;
            5'h10: y = 5'h1e;
            5'h11: y = 5'h13;
            5'h12: y = 5'h07;
            5'h13: y = 5'h0e;
            5'h14: y = 5'h00;
            5'h15: y = 5'h0d;
            5'h16: y = 5'h11;
            5'h17: y = 5'h18;
            5'h18: y = 5'h10;
            5'h19: y = 5'h0c;
            5'h1a: y = 5'h01;
            5'h1b: y = 5'h19;
            5'h1c: y = 5'h16;
            5'h1d: y = 5'h0a;
            5'h1e: y = 5'h0f;
            default: y = 5'h17;
        endcase
        return y;
    endfunction

    // Substitution layer: the S-box applied to each of the 64 bit columns.
    function automatic logic [4:0][63:0] substitution_layer(input logic [4:0][63:0] s);
        logic [4:0][63:0] r;
        logic [4:0]       col;
        logic [4:0]       y;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            col     = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            y       = sbox(col);
            r[0][j] = y[4];
            r[1][j] = y[3];
            r[2][j] = y[2];
            r[3][j] = y[1];
            r[4][j] = y[0];
        end
        return r;
    endfunction

    // 64-bit rotate right by a constant amount (1..63).
    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Linear diffusion: each word is mixed with two rotated copies of itself.
    function automatic logic [4:0][63:0] linear_layer(input logic [4:0][63:0] s);
        logic [4:0][63:0] r;
        r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        r[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
        r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        r[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
        return r;
    endfunction

    // Round constant: high nibble counts down from 3, low nibble counts up from 12.
    function automatic logic [7:0] round_constant(input logic [3:0] k);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'd3 - k;
        lo = k + 4'd12;
        return {hi, lo};
    endfunction

    // One complete Ascon-p round for round index k.
    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                      input logic [3:0]       k);
        logic [4:0][63:0] t;
        t       = s;
        t[2][7:0] = t[2][7:0] ^ round_constant(k);
        return linear_layer(substitution_layer(t));
    endfunction

    assign nr_eff      = (nr_i > MAX_NR) ? MAX_NR : nr_i;
    assign round_start = 5'd16 - nr_eff;
    assign accept      = in_valid_i && (fsm_q == IDLE);

`ifdef ASCON_PERM_UNROLL2_EN
    logic [4:0][63:0] round_a;
    logic [4:0][63:0] round_b;

    // Two chained rounds per cycle; only the first is kept when k is the final round.
    always_comb begin
        round_a    = ascon_round(perm_q, round_q[3:0]);
        round_b    = ascon_round(round_a, round_q[3:0] + 4'd1);
        round_next = (round_q[3:0] == 4'd15) ? round_a : round_b;
    end

    assign round_step = 5'd2;
    assign last_cycle = (round_q >= 5'd14);
`else
    // Single round per cycle.
    always_comb begin
        round_next = ascon_round(perm_q, round_q[3:0]);
    end

    assign round_step = 5'd1;
    assign last_cycle = (round_q == 5'd15);
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state decode: accept in IDLE, iterate in RUN, hand off in DONE.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    fsm_d = (nr_eff == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_cycle) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the FSM state alone.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (fsm_q)
            IDLE: in_ready_o = 1'b1;
            RUN:  busy_o     = 1'b1;
            DONE: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            default: in_ready_o = 1'b0;
        endcase
    end

    // Permutation state and round index: load on accept, update in RUN, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perm_q  <= '0;
            round_q <= 5'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        perm_q  <= state_i;
                        round_q <= round_start;
                    end
                end
                RUN: begin
                    perm_q  <= round_next;
                    round_q <= round_q + round_step;
                end
                default: begin
                    perm_q  <= perm_q;
                    round_q <= round_q;
                end
            endcase
        end
    end

    assign state_o = perm_q;

endmodule

// File: tb/tb_ascon_permutation_sequencer.sv
// tb_ascon_permutation_sequencer
// Self-checking bench for the Ascon-p round sequencer. Expected states come
// from a bit-sliced reference model and are queued when a permutation is
// submitted, then popped when the sequencer presents its result.

module tb_ascon_permutation_sequencer;

    typedef logic [4:0][63:0] st_t;

    localparam int MAX_R = 12;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    st_t        state_in;
    logic [4:0] nr_in;
    logic       out_valid;
    logic       out_ready;
    st_t        state_out;
    logic       busy;

    int passed = 0;
    int total  = 0;

    st_t exp_q[$];

    ascon_permutation_sequencer #(
        .MAX_ROUNDS(MAX_R)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .state_i    (state_in),
        .nr_i       (nr_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .state_o    (state_out),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round constants of Ascon-p indexed by round number k = 0..15.
    function automatic logic [7:0] rc(input int k);
        case (k)
            0:  return 8'h3c;
            1:  return 8'h2d;
            2:  return 8'h1e;
            3:  return 8'h0f;
            4:  return 8'hf0;
            5:  return 8'he1;
            6:  return 8'hd2;
            7:  return 8'hc3;
            8:  return 8'hb4;
            9:  return 8'ha5;
            10: return 8'h96;
            11: return 8'h87;
            12: return 8'h78;
            13: return 8'h69;
            14: return 8'h5a;
            default: return 8'h4b;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Bit-sliced reference Ascon-p with nr rounds (k = 16-nr .. 15).
    function automatic st_t ascon_model(input st_t s, input int nr);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        st_t r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        for (int k = 16 - nr; k < 16; k++) begin
            x2 = x2 ^ {56'h0, rc(k)};
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
            x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
            x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
            x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
            x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        end
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
        return r;
    endfunction

    function automatic int clamp_nr(input int nr);
        return (nr > MAX_R) ? MAX_R : nr;
    endfunction

    // Edges from the accepting edge until out_valid_o is seen.
    function automatic int exp_latency(input int nr);
        int e;
        e = clamp_nr(nr);
`ifdef ASCON_PERM_UNROLL2_EN
        return (e + 1) / 2;
`else
        return e;
`endif
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic st_t pop_expected();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Submit one permutation and queue its expected result; ends one half cycle after the accept edge.
    task automatic send_input(input st_t s, input logic [4:0] nr);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            total++;
            $display("[TB] FAIL accept_timeout: in_ready_o=%0b after %0d cycles, required 1", in_ready, guard);
        end
        in_valid = 1'b1;
        state_in = s;
        nr_in    = nr;
        exp_q.push_back(ascon_model(s, clamp_nr(int'(nr))));
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid_o, counting edges; a timeout is reported as a failure.
    task automatic wait_output(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            total++;
            $display("[TB] FAIL output_timeout: out_valid_o=%0b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic release_output();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0; nr_in = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b, required 0", busy); else passed++;
        total++; if (state_out !== '0) $display("[TB] FAIL reset_state: got %h, required 0", state_out); else passed++;
    endtask

    task automatic test_nr0();
        st_t s, e;
        int lat;
        for (int i = 0; i < 5; i++) s[i] = 64'(i);
        send_input(s, 5'd0);
        wait_output(lat);
        e = pop_expected();
        total++; if (lat !== exp_latency(0)) $display("[TB] FAIL nr0_latency: got %0d, required %0d", lat, exp_latency(0)); else passed++;
        total++; if (state_out !== s) $display("[TB] FAIL nr0_passthrough: got %h, required %h", state_out, s); else passed++;
        total++; if (state_out !== e) $display("[TB] FAIL nr0_model: got %h, required %h", state_out, e); else passed++;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("[TB] FAIL nr0_done_flags: busy=%0b in_ready=%0b, required 1/0", busy, in_ready); else passed++;
        release_output();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL nr0_release: out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_nr1_zero();
        st_t e;
        int lat;
        send_input('0, 5'd1);
        wait_output(lat);
        e = pop_expected();
        total++; if (lat !== exp_latency(1)) $display("[TB] FAIL nr1_latency: got %0d, required %0d", lat, exp_latency(1)); else passed++;
        total++; if (state_out[0] !== 64'h0009_64B0_0000_004B) $display("[TB] FAIL nr1_s0: got %h, required 000964b00000004b", state_out[0]); else passed++;
        total++; if (state_out[4] !== 64'h0) $display("[TB] FAIL nr1_s4: got %h, required 0", state_out[4]); else passed++;
        total++; if (state_out !== e) $display("[TB] FAIL nr1_model: got %h, required %h", state_out, e); else passed++;
        release_output();
    endtask

    task automatic test_random_stall();
        st_t s, e;
        int lat, stall, nr;
        for (int i = 0; i < 6; i++) begin
            nr = (i % 2 == 0) ? 12 : 8;
            s  = rand_state();
            send_input(s, 5'(nr));
            total++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL stall_run_flags: in_ready=%0b busy=%0b, required 0/1", in_ready, busy); else passed++;
            state_in = rand_state();
            in_valid = 1'b1;
            wait_output(lat);
            in_valid = 1'b0;
            e = pop_expected();
            total++; if (lat !== exp_latency(nr)) $display("[TB] FAIL stall_latency_nr%0d: got %0d, required %0d", nr, lat, exp_latency(nr)); else passed++;
            total++; if (state_out !== e) $display("[TB] FAIL stall_result_nr%0d: got %h, required %h", nr, state_out, e); else passed++;
            stall = $urandom_range(0, 5);
            for (int c = 0; c < stall; c++) begin
                state_in = rand_state();
                @(posedge clk); @(negedge clk);
                total++; if (out_valid !== 1'b1 || state_out !== e) $display("[TB] FAIL stall_hold: out_valid=%0b state=%h, required 1 and %h", out_valid, state_out, e); else passed++;
            end
            release_output();
        end
    endtask

    task automatic test_clamp();
        st_t s, e;
        int lat;
        s = rand_state();
        send_input(s, 5'd20);
        wait_output(lat);
        e = pop_expected();
        total++; if (lat !== exp_latency(12)) $display("[TB] FAIL clamp_latency: got %0d, required %0d", lat, exp_latency(12)); else passed++;
        total++; if (state_out !== ascon_model(s, 12)) $display("[TB] FAIL clamp_result: got %h, required %h", state_out, e); else passed++;
        release_output();
    endtask

    task automatic test_reset_mid_run();
        st_t e;
        int lat;
        send_input(rand_state(), 5'd12);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL midrst_running: busy=%0b out_valid=%0b, required 1/0", busy, out_valid); else passed++;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %0b, required 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %0b, required 0", out_valid); else passed++;
        total++; if (state_out !== '0) $display("[TB] FAIL midrst_state: got %h, required 0", state_out); else passed++;
        send_input(rand_state(), 5'd12);
        wait_output(lat);
        e = pop_expected();
        total++; if (state_out !== e) $display("[TB] FAIL midrst_fresh_run: got %h, required %h", state_out, e); else passed++;
        release_output();
    endtask

    task automatic test_back_to_back();
        st_t e;
        int cyc, accepts, outputs, last_acc, period;
        cyc = 0; accepts = 0; outputs = 0; last_acc = -1;
        period = exp_latency(4) + 2;
        nr_in = 5'd4;
        out_ready = 1'b1;
        while (outputs < 5 && cyc < 300) begin
            in_valid = (accepts < 5);
            state_in = rand_state();
            if (in_ready && in_valid) begin
                exp_q.push_back(ascon_model(state_in, 4));
                if (last_acc >= 0) begin
                    total++; if (cyc - last_acc !== period) $display("[TB] FAIL b2b_period: got %0d, required %0d", cyc - last_acc, period); else passed++;
                end
                last_acc = cyc;
                accepts++;
            end
            if (out_valid) begin
                e = pop_expected();
                total++; if (state_out !== e) $display("[TB] FAIL b2b_result: got %h, required %h", state_out, e); else passed++;
                outputs++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (outputs !== 5) $display("[TB] FAIL b2b_outputs: got %0d, required 5", outputs); else passed++;
    endtask

    initial begin
        test_reset();
        test_nr0();
        test_nr1_zero();
        test_random_stall();
        test_clamp();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
